// File: rtl/ber_pkg.sv
// Shared definitions for the 16-QAM PRBS-22 BER checker: LFSR geometry, FSM states,
// feedback and bit-error helpers.
package ber_pkg;

  localparam int LFSR_W = 22;
  localparam int TAP_A  = 21;
  localparam int TAP_B  = 18;
  localparam int TAP_C  = 17;
  localparam int TAP_D  = 16;
  localparam int SYM_W  = 2;

  typedef enum logic {
    ACQUIRE = 1'b0,
    TRACK   = 1'b1
  } state_e;

  // x^22 + x^19 + x^18 + x^17 + 1, newest bit shifts in at bit 0
  function automatic logic prbs22_fb(input logic [LFSR_W-1:0] q);
    return q[TAP_A] ^ q[TAP_B] ^ q[TAP_C] ^ q[TAP_D];
  endfunction

  function automatic logic [2:0] popcount4(input logic [3:0] d);
    return {2'b00, d[0]} + {2'b00, d[1]} + {2'b00, d[2]} + {2'b00, d[3]};
  endfunction

endpackage

// File: rtl/ber_lock_monitor.sv
// Counts symbols and errored symbols in fixed windows and flags loss of lock
// combinationally on the strobe that closes a window with too many errored symbols.
module ber_lock_monitor
  import ber_pkg::*;
#(
  parameter int LOCK_WIN    = 64,
  parameter int LOCK_THRESH = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic sym_stb,
  input  logic sym_err,
  output logic lose_lock
);

  localparam int CW = $clog2(LOCK_WIN + 1);

  logic [CW-1:0] lock_sym_q, lock_sym_d;
  logic [CW-1:0] lock_err_q, lock_err_d;
  logic [CW-1:0] err_inc;

  // Window counters; the verdict includes the symbol arriving on the closing strobe
  always_comb begin
    lock_sym_d = lock_sym_q;
    lock_err_d = lock_err_q;
    lose_lock  = 1'b0;
    err_inc    = lock_err_q + CW'(sym_err);
    if (clr) begin
      lock_sym_d = '0;
      lock_err_d = '0;
    end else if (sym_stb) begin
      if (lock_sym_q == CW'(LOCK_WIN - 1)) begin
        lose_lock  = (err_inc > CW'(LOCK_THRESH));
        lock_sym_d = '0;
        lock_err_d = '0;
      end else begin
        lock_sym_d = lock_sym_q + CW'(1);
        lock_err_d = err_inc;
      end
    end else begin
      lock_sym_d = lock_sym_q;
    end
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      lock_sym_q <= '0;
      lock_err_q <= '0;
    end else begin
      lock_sym_q <= lock_sym_d;
      lock_err_q <= lock_err_d;
    end
  end

endmodule

// File: rtl/ber_checker_qam16.sv
// Self-synchronising PRBS-22 BER checker for sliced 16-QAM symbols: acquires the local
// LFSR from received I[0] bits, then counts bit errors over back-to-back windows.
module ber_checker_qam16
  import ber_pkg::*;
#(
  parameter int BER_SYMS    = 4194303,
  parameter int LOCK_WIN    = 64,
  parameter int LOCK_THRESH = 16,
  parameter int CNT_W       = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sam_clk_ena,
  input  logic [1:0]       I_sym_rx,
  input  logic [1:0]       Q_sym_rx,
  output logic             locked,
  output logic [CNT_W-1:0] err_total,
  output logic [CNT_W-1:0] sym_total,
  output logic             ber_done,
  output logic             lock_lost
);

  state_e              state_q, state_d;
  logic [LFSR_W-1:0]   q_loc_q, q_loc_d;
  logic [4:0]          acq_cnt_q, acq_cnt_d;
  logic [CNT_W-1:0]    err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0]    sym_cnt_q, sym_cnt_d;
  logic                locked_q, locked_d;
  logic [CNT_W-1:0]    err_total_q, err_total_d;
  logic [CNT_W-1:0]    sym_total_q, sym_total_d;
  logic                ber_done_q, ber_done_d;
  logic                lock_lost_q, lock_lost_d;

  logic                fb;
  logic [3:0]          diff;
  logic [2:0]          bit_errs;
  logic [CNT_W:0]      err_sum;
  logic [CNT_W-1:0]    err_next;
  logic [LFSR_W-1:0]   acq_shift;
  logic                track_stb;
  logic                enter_track;
  logic                lose_lock;

  ber_lock_monitor #(
    .LOCK_WIN    (LOCK_WIN),
    .LOCK_THRESH (LOCK_THRESH)
  ) u_lock_mon (
    .clk       (clk),
    .reset     (reset),
    .clr       (enter_track),
    .sym_stb   (track_stb),
    .sym_err   (|diff),
    .lose_lock (lose_lock)
  );

  // Acquire/track FSM with PRBS prediction and saturating window counters
  always_comb begin
    fb          = prbs22_fb(q_loc_q);
    diff        = {q_loc_q[2:0], fb} ^ {Q_sym_rx, I_sym_rx};
    bit_errs    = popcount4(diff);
    err_sum     = {1'b0, err_cnt_q} + (CNT_W+1)'(bit_errs);
    err_next    = err_sum[CNT_W] ? {CNT_W{1'b1}} : err_sum[CNT_W-1:0];
    acq_shift   = {q_loc_q[LFSR_W-2:0], I_sym_rx[0]};
    track_stb   = sam_clk_ena && (state_q == TRACK);
    enter_track = 1'b0;

    state_d     = state_q;
    q_loc_d     = q_loc_q;
    acq_cnt_d   = acq_cnt_q;
    err_cnt_d   = err_cnt_q;
    sym_cnt_d   = sym_cnt_q;
    locked_d    = locked_q;
    err_total_d = err_total_q;
    sym_total_d = sym_total_q;
    ber_done_d  = 1'b0;
    lock_lost_d = 1'b0;

    case (state_q)
      ACQUIRE: begin
        if (sam_clk_ena) begin
          q_loc_d = acq_shift;
          if (acq_cnt_q == 5'(LFSR_W - 1)) begin
            acq_cnt_d = 5'd0;
            // an all-zero register is the LFSR lockup state, keep acquiring
            if (acq_shift != {LFSR_W{1'b0}}) begin
              state_d     = TRACK;
              locked_d    = 1'b1;
              enter_track = 1'b1;
              err_cnt_d   = '0;
              sym_cnt_d   = '0;
            end else begin
              state_d = ACQUIRE;
            end
          end else begin
            acq_cnt_d = acq_cnt_q + 5'd1;
          end
        end else begin
          state_d = ACQUIRE;
        end
      end
      TRACK: begin
        if (sam_clk_ena) begin
          q_loc_d = {q_loc_q[LFSR_W-2:0], fb};
          if (lose_lock) begin
            state_d     = ACQUIRE;
            locked_d    = 1'b0;
            lock_lost_d = 1'b1;
            acq_cnt_d   = 5'd0;
          end else if (sym_cnt_q == CNT_W'(BER_SYMS - 1)) begin
            err_total_d = err_next;
            sym_total_d = CNT_W'(BER_SYMS);
            ber_done_d  = 1'b1;
            err_cnt_d   = '0;
            sym_cnt_d   = '0;
          end else begin
            err_cnt_d = err_next;
            sym_cnt_d = sym_cnt_q + CNT_W'(1);
          end
        end else begin
          state_d = TRACK;
        end
      end
      default: begin
        state_d  = ACQUIRE;
        locked_d = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ACQUIRE;
      q_loc_q     <= '0;
      acq_cnt_q   <= 5'd0;
      err_cnt_q   <= '0;
      sym_cnt_q   <= '0;
      locked_q    <= 1'b0;
      err_total_q <= '0;
      sym_total_q <= '0;
      ber_done_q  <= 1'b0;
      lock_lost_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      q_loc_q     <= q_loc_d;
      acq_cnt_q   <= acq_cnt_d;
      err_cnt_q   <= err_cnt_d;
      sym_cnt_q   <= sym_cnt_d;
      locked_q    <= locked_d;
      err_total_q <= err_total_d;
      sym_total_q <= sym_total_d;
      ber_done_q  <= ber_done_d;
      lock_lost_q <= lock_lost_d;
    end
  end

  assign locked    = locked_q;
  assign err_total = err_total_q;
  assign sym_total = sym_total_q;
  assign ber_done  = ber_done_q;
  assign lock_lost = lock_lost_q;

endmodule
